// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and loads
// the IF/ID pipeline register. Handles stall, branch redirect and exception
// flush, with flush taking priority over stall, and stall over branch.
// Optional feature: define IF_DELAY_SLOT_EN for a MIPS-style branch delay
// slot, where the instruction fetched on a branch edge is kept. Without it,
// that instruction is squashed.
module if_stage #(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_W-1:0] NOP_INST     = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flushAddr,
  input  logic              branchEn,
  input  logic [ADDR_W-1:0] branchAddr,
  output logic              romCe,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [DATA_W-1:0] romData,
  output logic [DATA_W-1:0] idInst,
  output logic [ADDR_W-1:0] idPc,
  output logic              idValid
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0]   id_pc_q, id_pc_d;
  logic                valid_q, valid_d;

  // Instruction addresses are word aligned; the low two bits are dropped on
  // every load.
  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  // State register: leaves IDLE on the first edge out of reset, never returns.
  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of the others; blocking here would create order-dependent
  // simulation and mismatch synthesis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE lasts exactly one edge after reset release.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      state_d = RUN;
    end
  end

  // Output logic: the ROM is enabled whenever the stage is running.
  always_comb begin
    romCe   = (state_q == RUN);
    romAddr = pc_q;
  end

  // PC and IF/ID next-state: flush > stall > branch > sequential fetch.
  // While IDLE nothing moves, so romData (not enabled) is never captured.
  // NOTE: every variable gets its hold value first, so no path through the
  // branches leaves one unassigned and no latch is inferred.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    id_pc_d = id_pc_q;
    valid_d = valid_q;
    if (state_q == RUN) begin
      if (flush) begin
        pc_d    = align(flushAddr);
        inst_d  = NOP_INST;
        id_pc_d = '0;
        valid_d = 1'b0;
      end else if (stall) begin
        // Hold everything; ID keeps presenting any pending branch.
      end else if (branchEn) begin
        pc_d = align(branchAddr);
`ifdef IF_DELAY_SLOT_EN
        inst_d  = romData;
        id_pc_d = pc_q;
        valid_d = 1'b1;
`else
        inst_d  = NOP_INST;
        id_pc_d = '0;
        valid_d = 1'b0;
`endif
      end else begin
        // Sequential fetch; the add wraps modulo 2^ADDR_W.
        pc_d    = pc_q + ADDR_W'(4);
        inst_d  = romData;
        id_pc_d = pc_q;
        valid_d = 1'b1;
      end
    end
  end

  // PC and IF/ID pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= align(RESET_VECTOR);
      inst_q  <= NOP_INST;
      id_pc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      id_pc_q <= id_pc_d;
      valid_q <= valid_d;
    end
  end

  assign idInst  = inst_q;
  assign idPc    = id_pc_q;
  assign idValid = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios, a per-cycle reference model and a
// set of hand-computed literal expectations.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] flushAddr;
  logic        branchEn;
  logic [31:0] branchAddr;
  logic        romCe;
  logic [31:0] romAddr;
  logic [31:0] romData;
  logic [31:0] idInst;
  logic [31:0] idPc;
  logic        idValid;

  int total = 0;
  int bad   = 0;
  logic cmp_en = 1'b0;

  if_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .flushAddr  (flushAddr),
    .branchEn   (branchEn),
    .branchAddr (branchAddr),
    .romCe      (romCe),
    .romAddr    (romAddr),
    .romData    (romData),
    .idInst     (idInst),
    .idPc       (idPc),
    .idValid    (idValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: three fixed words, everything else derived from address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  // Disabled ROM returns garbage that must never be captured.
  assign romData = romCe ? rom_word(romAddr) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the stage must hold after each edge.
  logic        m_run;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_idpc;
  logic        m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run   <= 1'b0;
      m_pc    <= 32'h0;
      m_inst  <= 32'h0;
      m_idpc  <= 32'h0;
      m_valid <= 1'b0;
    end else if (!m_run) begin
      m_run <= 1'b1;
    end else if (flush) begin
      m_pc    <= flushAddr & ~32'h3;
      m_inst  <= 32'h0;
      m_idpc  <= 32'h0;
      m_valid <= 1'b0;
    end else if (!stall) begin
      if (branchEn) begin
        m_pc <= branchAddr & ~32'h3;
`ifdef IF_DELAY_SLOT_EN
        m_inst  <= rom_word(m_pc);
        m_idpc  <= m_pc;
        m_valid <= 1'b1;
`else
        m_inst  <= 32'h0;
        m_idpc  <= 32'h0;
        m_valid <= 1'b0;
`endif
      end else begin
        m_pc    <= m_pc + 32'd4;
        m_inst  <= rom_word(m_pc);
        m_idpc  <= m_pc;
        m_valid <= 1'b1;
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_romCe",   {31'b0, romCe},   {31'b0, m_run});
      check("cmp_romAddr", romAddr,          m_pc);
      check("cmp_idInst",  idInst,           m_inst);
      check("cmp_idPc",    idPc,             m_idpc);
      check("cmp_idValid", {31'b0, idValid}, {31'b0, m_valid});
    end
  end

  // Apply inputs (at a falling edge) for one rising edge, then return at the
  // next falling edge.
  task automatic step(input logic s, input logic f, input logic [31:0] fa,
                      input logic b, input logic [31:0] ba);
    stall      = s;
    flush      = f;
    flushAddr  = fa;
    branchEn   = b;
    branchAddr = ba;
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Scenario 1: reset release then fetch of 0, 4, 8.
  task automatic startup_seq(input string tag);
    idle_step();
    check({tag, "_idle_romCe"},   {31'b0, romCe},   32'h1);
    check({tag, "_idle_romAddr"}, romAddr,          32'h0);
    check({tag, "_idle_valid"},   {31'b0, idValid}, 32'h0);
    idle_step();
    check({tag, "_f0_inst"}, idInst,  32'h11);
    check({tag, "_f0_pc"},   idPc,    32'h0);
    check({tag, "_f0_addr"}, romAddr, 32'h4);
    idle_step();
    check({tag, "_f1_inst"}, idInst,  32'h22);
    check({tag, "_f1_pc"},   idPc,    32'h4);
    check({tag, "_f1_addr"}, romAddr, 32'h8);
  endtask

  initial begin
    rst_n      = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    flushAddr  = 32'h0;
    branchEn   = 1'b0;
    branchAddr = 32'h0;

    @(negedge clk);
    check("rst_romCe",   {31'b0, romCe},   32'h0);
    check("rst_romAddr", romAddr,          32'h0);
    check("rst_idInst",  idInst,           32'h0);
    check("rst_idPc",    idPc,             32'h0);
    check("rst_idValid", {31'b0, idValid}, 32'h0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    startup_seq("s1");

    // Scenario 2: stall three cycles at pc=8, branch request ignored meanwhile.
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h400);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stall_addr", romAddr, 32'h8);
    check("stall_inst", idInst,  32'h22);
    check("stall_pc",   idPc,    32'h4);
    idle_step();
    check("resume_inst", idInst,  32'h33);
    check("resume_pc",   idPc,    32'h8);
    check("resume_addr", romAddr, 32'hC);

    // Scenario 3: branch at pc=0xC to unaligned 0x103.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h103);
    check("br_addr", romAddr, 32'h100);
`ifdef IF_DELAY_SLOT_EN
    check("br_pc",    idPc,             32'hC);
    check("br_valid", {31'b0, idValid}, 32'h1);
    check("br_inst",  idInst,           32'hC0DE000C);
`else
    check("br_pc",    idPc,             32'h0);
    check("br_valid", {31'b0, idValid}, 32'h0);
    check("br_inst",  idInst,           32'h0);
`endif
    idle_step();
    check("br_tgt_inst", idInst, 32'hC0DE0100);
    check("br_tgt_pc",   idPc,   32'h100);

    // Scenario 4: flush beats stall and branch in the same cycle.
    step(1'b1, 1'b1, 32'h181, 1'b1, 32'h200);
    check("fl_addr",  romAddr,          32'h180);
    check("fl_valid", {31'b0, idValid}, 32'h0);
    check("fl_pc",    idPc,             32'h0);
    idle_step();
    check("fl_tgt_pc", idPc, 32'h180);

    // Scenario 5: wrap from 0xFFFF_FFFC to 0.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    check("wrap_load", romAddr, 32'hFFFF_FFFC);
    idle_step();
    check("wrap_addr", romAddr, 32'h0);
    check("wrap_pc",   idPc,    32'hFFFF_FFFC);
    check("wrap_inst", idInst,  32'hC0DEFFFC);
    idle_step();
    check("wrap_next_pc", idPc, 32'h0);

    // Scenario 6: asynchronous reset between edges, then restart.
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_romCe",   {31'b0, romCe},   32'h0);
    check("mid_rst_romAddr", romAddr,          32'h0);
    check("mid_rst_idValid", {31'b0, idValid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    startup_seq("s6");
    idle_step();
    check("s6_f2_inst", idInst, 32'h33);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
